// File: rtl/interrupt_controller12.sv
// interrupt_controller12: collects up to 24 edge-triggered request lines, masks
// and priority-encodes them, and hands one 24-bit handler vector at a time to
// the 12-bit core over a req/ack/done handshake. Mask and pending state are
// reachable through a small 12-bit register port.
module interrupt_controller12 #(
  parameter int          NUM_IRQ       = 24,
  parameter logic [23:0] VECTOR_BASE   = 24'o00000100,
  parameter logic [23:0] VECTOR_STRIDE = 24'o00000004
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         reg_sel,
  input  logic               reg_we,
  input  logic [11:0]        reg_wdata,
  output logic [11:0]        reg_rdata,
  output logic               int_req,
  output logic [23:0]        int_vector,
  input  logic               int_ack,
  input  logic               int_done
);

  // Bits at or above NUM_IRQ do not exist; every internal vector is clipped
  // with this so unimplemented positions always read 0. For NUM_IRQ=24 the
  // shift yields 0 and the subtraction wraps to all ones.
  localparam logic [23:0] IMPL_MASK = (24'd1 << NUM_IRQ) - 24'd1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t      state_reg, state_next;

  logic [23:0] irq_ext;
  logic [23:0] sync1_reg, sync2_reg, sync3_reg;
  logic [23:0] edge_evt;

  logic [23:0] mask_reg, mask_next;
  logic [23:0] pending_reg, pending_next;
  logic [23:0] w1c_bits;
  logic [23:0] ack_clr;
  logic [23:0] eligible;
  logic        any_eligible;

  logic [4:0]  win_idx;
  logic [23:0] win_vector;

  logic [4:0]  idx_reg;
  logic [23:0] idx_onehot;
  logic        latched_eligible;
  logic [23:0] vector_reg;

  logic        ack_take;
  logic        grant_load;
  logic        active;

  // Widen the request lines to the full 24-bit internal width.
  generate
    for (genvar gi = 0; gi < 24; gi++) begin : g_irq_ext
      if (gi < NUM_IRQ) begin : g_impl
        assign irq_ext[gi] = irq_in[gi];
      end else begin : g_unimpl
        assign irq_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      sync3_reg <= '0;
    end else begin
      sync1_reg <= irq_ext;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  // A held-high line produces exactly one event; it must fall and rise again.
  assign edge_evt = sync2_reg & ~sync3_reg;

  assign eligible     = pending_reg & mask_reg;
  assign any_eligible = |eligible;
  assign idx_onehot   = 24'd1 << idx_reg;
  assign latched_eligible = |(eligible & idx_onehot);

  // Lowest eligible index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win_idx = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_idx = 5'(i);
      end
    end
  end

  // Handler address, wrapping modulo 2^24.
  assign win_vector = VECTOR_BASE + VECTOR_STRIDE * {19'd0, win_idx};

  // Register-port writes: mask halves are plain stores, pending halves are W1C.
  always_comb begin
    mask_next = mask_reg;
    w1c_bits  = '0;
    if (reg_we) begin
      case (reg_sel)
        3'd0:    mask_next[11:0]  = reg_wdata;
        3'd1:    mask_next[23:12] = reg_wdata;
        3'd2:    w1c_bits         = {12'd0, reg_wdata};
        3'd3:    w1c_bits         = {reg_wdata, 12'd0};
        default: ;
      endcase
    end
    mask_next = mask_next & IMPL_MASK;
  end

  // Pending update: a new edge event overrides a clear in the same cycle.
  always_comb begin
    ack_clr      = ack_take ? idx_onehot : 24'd0;
    pending_next = ((pending_reg & ~(w1c_bits | ack_clr)) | edge_evt) & IMPL_MASK;
  end

  // Mask and pending storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg    <= '0;
      pending_reg <= '0;
    end else begin
      mask_reg    <= mask_next;
      pending_reg <= pending_next;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; in REQ an ack takes precedence over a withdrawal.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (any_eligible) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          state_next = S_SERVICE;
        end else if (!latched_eligible) begin
          state_next = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (int_done) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs and internal strobes decoded from the current state.
  always_comb begin
    int_req    = (state_reg == S_REQ);
    active     = (state_reg == S_SERVICE);
    ack_take   = (state_reg == S_REQ) && int_ack;
    grant_load = (state_reg == S_IDLE) && any_eligible;
  end

  // Winner index and vector are captured once and held for the whole request,
  // so a later higher-priority arrival cannot change what the core sees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg    <= 5'd0;
      vector_reg <= VECTOR_BASE;
    end else if (grant_load) begin
      idx_reg    <= win_idx;
      vector_reg <= win_vector;
    end
  end

  assign int_vector = vector_reg;

  // Register read mux, combinational from reg_sel.
  always_comb begin
    case (reg_sel)
      3'd0:    reg_rdata = mask_reg[11:0];
      3'd1:    reg_rdata = mask_reg[23:12];
      3'd2:    reg_rdata = pending_reg[11:0];
      3'd3:    reg_rdata = pending_reg[23:12];
      3'd4:    reg_rdata = {active, int_req, 5'd0, idx_reg};
      default: reg_rdata = 12'd0;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller12.sv
// tb_interrupt_controller12: directed scenarios plus a randomized phase, all
// checked every cycle against a behavioural model of the controller.
module tb_interrupt_controller12;

  localparam logic [23:0] BASE   = 24'o00000100;
  localparam logic [23:0] STRIDE = 24'o00000004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] irq_in = '0;
  logic [2:0]  reg_sel = '0;
  logic        reg_we = 1'b0;
  logic [11:0] reg_wdata = '0;
  logic [11:0] reg_rdata;
  logic        int_req;
  logic [23:0] int_vector;
  logic        int_ack = 1'b0;
  logic        int_done = 1'b0;

  int errors = 0;
  int checks = 0;

  interrupt_controller12 #(
    .NUM_IRQ(24),
    .VECTOR_BASE(BASE),
    .VECTOR_STRIDE(STRIDE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irq_in(irq_in),
    .reg_sel(reg_sel),
    .reg_we(reg_we),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .int_req(int_req),
    .int_vector(int_vector),
    .int_ack(int_ack),
    .int_done(int_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_st: 0 idle, 1 requesting, 2 in service
  bit [23:0] m_samp [3];
  bit [23:0] m_pend, m_mask, m_vec;
  int        m_st, m_idx;
  bit [23:0] mv_ev, mv_elig, mv_clr;
  int        mv_w;

  function automatic int lowest(input bit [23:0] e);
    for (int i = 0; i < 24; i++) if (e[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) m_samp[i] = '0;
      m_pend = '0; m_mask = '0; m_vec = BASE; m_st = 0; m_idx = 0;
    end else begin
      // an event is a line seen high two samples ago after being low three ago
      mv_ev = m_samp[1] & ~m_samp[2];
      m_samp[2] = m_samp[1]; m_samp[1] = m_samp[0]; m_samp[0] = irq_in;
      mv_elig = m_pend & m_mask;
      mv_w = lowest(mv_elig);
      mv_clr = '0;
      if (reg_we) begin
        case (reg_sel)
          3'd0: m_mask[11:0]  = reg_wdata;
          3'd1: m_mask[23:12] = reg_wdata;
          3'd2: mv_clr[11:0]  = reg_wdata;
          3'd3: mv_clr[23:12] = reg_wdata;
          default: ;
        endcase
      end
      if (m_st == 0) begin
        if (mv_w >= 0) begin
          m_st = 1; m_idx = mv_w; m_vec = BASE + STRIDE * mv_w[23:0];
        end
      end else if (m_st == 1) begin
        if (int_ack) begin
          mv_clr[m_idx] = 1'b1; m_st = 2;
        end else if (!mv_elig[m_idx]) begin
          m_st = 0;
        end
      end else begin
        if (int_done) m_st = 0;
      end
      m_pend = (m_pend & ~mv_clr) | mv_ev;
    end
  end

  function automatic logic [11:0] exp_rdata(input logic [2:0] sel);
    case (sel)
      3'd0: return m_mask[11:0];
      3'd1: return m_mask[23:12];
      3'd2: return m_pend[11:0];
      3'd3: return m_pend[23:12];
      3'd4: return {m_st == 2, m_st == 1, 5'd0, 5'(m_idx)};
      default: return 12'd0;
    endcase
  endfunction

  // Per-cycle comparison, away from the active edge.
  always @(posedge clk) begin
    #2;
    chk("int_req", {31'd0, int_req}, {31'd0, m_st == 1});
    chk("int_vector", {8'd0, int_vector}, {8'd0, m_vec});
    chk("reg_rdata", {20'd0, reg_rdata}, {20'd0, exp_rdata(reg_sel)});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] sel, input logic [11:0] data);
    reg_sel = sel; reg_we = 1'b1; reg_wdata = data;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, output logic [11:0] data);
    reg_sel = sel;
    #1;
    data = reg_rdata;
  endtask

  task automatic pulse(input logic [23:0] bits, input int n);
    irq_in = irq_in | bits;
    repeat (n) tick();
    irq_in = irq_in & ~bits;
  endtask

  task automatic wait_req(input string name, input int max);
    int n = 0;
    while (!int_req && n < max) begin
      tick();
      n++;
    end
    chk({name, " req timeout"}, {31'd0, int_req}, 32'd1);
  endtask

  task automatic ack_done();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    int_done = 1'b1; tick(); int_done = 1'b0;
  endtask

  logic [11:0] rv;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // T1: reset state, then single source with latency and vector
    rd(3'd0, rv); chk("T1 mask reset", {20'd0, rv}, 32'h0);
    rd(3'd4, rv); chk("T1 status reset", {20'd0, rv}, 32'h0);
    chk("T1 vector reset", {8'd0, int_vector}, 32'o100);
    wr(3'd0, 12'hFFF); wr(3'd1, 12'hFFF);
    irq_in[3] = 1'b1;
    tick(); tick(); tick();
    chk("T1 req early", {31'd0, int_req}, 32'd0);
    tick();
    chk("T1 req latency", {31'd0, int_req}, 32'd1);
    chk("T1 vector", {8'd0, int_vector}, 32'o114);
    rd(3'd4, rv); chk("T1 status", {20'd0, rv}, 32'h403);
    irq_in[3] = 1'b0;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("T1 req after ack", {31'd0, int_req}, 32'd0);
    rd(3'd4, rv); chk("T1 status service", {20'd0, rv}, 32'h803);
    int_done = 1'b1; tick(); int_done = 1'b0;

    // T2: two sources, priority then back-to-back gap
    pulse(24'h000088, 2);
    wait_req("T2a", 10);
    chk("T2 first vector", {8'd0, int_vector}, 32'o114);
    ack_done();
    chk("T2 gap", {31'd0, int_req}, 32'd0);
    tick();
    chk("T2 second req", {31'd0, int_req}, 32'd1);
    chk("T2 second vector", {8'd0, int_vector}, 32'o134);
    ack_done();

    // T3: masked event stays pending until unmasked
    wr(3'd0, 12'h000); wr(3'd1, 12'h000);
    pulse(24'h000001, 2);
    repeat (4) tick();
    chk("T3 masked req", {31'd0, int_req}, 32'd0);
    rd(3'd2, rv); chk("T3 pending", {20'd0, rv}, 32'h001);
    wr(3'd0, 12'h001);
    chk("T3 req not yet", {31'd0, int_req}, 32'd0);
    tick();
    chk("T3 req after unmask", {31'd0, int_req}, 32'd1);
    chk("T3 vector", {8'd0, int_vector}, 32'o100);
    ack_done();
    wr(3'd0, 12'hFFF); wr(3'd1, 12'hFFF);

    // T4: withdraw by W1C, then W1C together with ack
    pulse(24'h000020, 2);
    wait_req("T4a", 10);
    chk("T4 vector", {8'd0, int_vector}, 32'o124);
    wr(3'd2, 12'h020);
    tick();
    chk("T4 withdrawn", {31'd0, int_req}, 32'd0);
    rd(3'd4, rv); chk("T4 status idle", {20'd0, rv}, 32'h005);
    pulse(24'h000020, 2);
    wait_req("T4b", 10);
    reg_sel = 3'd2; reg_we = 1'b1; reg_wdata = 12'h020; int_ack = 1'b1;
    tick();
    reg_we = 1'b0; int_ack = 1'b0;
    chk("T4 ack wins req", {31'd0, int_req}, 32'd0);
    rd(3'd4, rv); chk("T4 ack wins status", {20'd0, rv}, 32'h805);
    int_done = 1'b1; tick(); int_done = 1'b0;

    // T5: new edge landing in the ack cycle survives the ack clear
    pulse(24'h000004, 2);
    wait_req("T5a", 10);
    irq_in[2] = 1'b1;
    tick(); tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    irq_in[2] = 1'b0;
    rd(3'd2, rv); chk("T5 pending kept", {20'd0, rv}, 32'h004);
    rd(3'd4, rv); chk("T5 status", {20'd0, rv}, 32'h802);
    int_done = 1'b1; tick(); int_done = 1'b0;
    tick();
    chk("T5 re-request", {31'd0, int_req}, 32'd1);
    chk("T5 vector", {8'd0, int_vector}, 32'o110);
    ack_done();

    // T6: asynchronous reset while in service
    pulse(24'h000200, 2);
    wait_req("T6", 10);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    reg_sel = 3'd4;
    #2 rst = 1'b1;
    #1;
    chk("T6 req in reset", {31'd0, int_req}, 32'd0);
    chk("T6 vector in reset", {8'd0, int_vector}, 32'o100);
    chk("T6 status in reset", {20'd0, reg_rdata}, 32'h0);
    tick();
    rst = 1'b0;
    rd(3'd0, rv); chk("T6 mask0 after reset", {20'd0, rv}, 32'h0);
    rd(3'd1, rv); chk("T6 mask1 after reset", {20'd0, rv}, 32'h0);
    tick();

    // Randomized phase: per-cycle model comparison does the checking
    wr(3'd0, 12'hFFF); wr(3'd1, 12'hFFF);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 24; b++) begin
        if ($urandom_range(0, 9) == 0) irq_in[b] = ~irq_in[b];
      end
      reg_sel   = 3'($urandom_range(0, 7));
      reg_we    = ($urandom_range(0, 9) == 0);
      reg_wdata = 12'($urandom);
      if (reg_we && reg_sel < 3'd2 && $urandom_range(0, 1) == 1) reg_wdata = 12'hFFF;
      int_ack   = int_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      int_done  = ($urandom_range(0, 3) == 0);
      tick();
    end
    reg_we = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
